// File: rtl/arc4_sched_if.sv
// Lane-side and engine-side handshake/bus bundle for the ARC4 phase scheduler.
// slave = scheduler view, master = lane controller + engines + S memory view.
interface arc4_sched_if #(
  parameter int KEY_W = 24
);
  logic             en;
  logic             rdy;
  logic [KEY_W-1:0] key;
  logic [KEY_W-1:0] key_q;
  logic [1:0]       phase;
  logic             err;

  logic             init_en, ksa_en, prga_en;
  logic             init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]       init_addr, init_wrdata;
  logic [7:0]       ksa_addr, ksa_wrdata;
  logic [7:0]       prga_addr, prga_wrdata;
  logic             init_wren, ksa_wren, prga_wren;

  logic [7:0]       s_addr, s_wrdata;
  logic             s_wren;

  modport slave (
    input  en, key,
    input  init_rdy, ksa_rdy, prga_rdy,
    input  init_addr, init_wrdata, init_wren,
    input  ksa_addr, ksa_wrdata, ksa_wren,
    input  prga_addr, prga_wrdata, prga_wren,
    output rdy, key_q, phase, err,
    output init_en, ksa_en, prga_en,
    output s_addr, s_wrdata, s_wren
  );

  modport master (
    output en, key,
    output init_rdy, ksa_rdy, prga_rdy,
    output init_addr, init_wrdata, init_wren,
    output ksa_addr, ksa_wrdata, ksa_wren,
    output prga_addr, prga_wrdata, prga_wren,
    input  rdy, key_q, phase, err,
    input  init_en, ksa_en, prga_en,
    input  s_addr, s_wrdata, s_wren
  );
endinterface

// File: rtl/arc4_sched.sv
// ARC4 phase scheduler: runs init -> ksa -> prga via en/rdy and muxes the S-memory path to the owner.
// ARC4_SCHED_TIMEOUT_EN adds a per-phase watchdog that aborts to IDLE and raises sticky err.
module arc4_sched #(
  parameter int KEY_W   = 24,
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  arc4_sched_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN
  } state_t;

  state_t           state, state_nxt;
  logic             seen_busy;
  logic [KEY_W-1:0] key_r;
  logic [1:0]       owner;
  logic             own_rdy, is_go, is_run;
  logic             accept, run_entry, complete, tmo_hit;

  // Owner is a pure function of state, so engine rdy never reaches s_*.
  always_comb begin
    owner = 2'd0;
    case (state)
      INIT_GO, INIT_RUN: owner = 2'd1;
      KSA_GO,  KSA_RUN:  owner = 2'd2;
      PRGA_GO, PRGA_RUN: owner = 2'd3;
      default:           owner = 2'd0;
    endcase
  end

  always_comb begin
    own_rdy = 1'b0;
    case (owner)
      2'd1:    own_rdy = bus.init_rdy;
      2'd2:    own_rdy = bus.ksa_rdy;
      2'd3:    own_rdy = bus.prga_rdy;
      default: own_rdy = 1'b0;
    endcase
  end

  assign is_go     = state inside {INIT_GO, KSA_GO, PRGA_GO};
  assign is_run    = state inside {INIT_RUN, KSA_RUN, PRGA_RUN};
  assign accept    = (state == IDLE) && bus.en;
  assign run_entry = is_go && own_rdy;
  // An engine that was idle at GO must be seen busy before its rdy counts as done.
  assign complete  = is_run && own_rdy && seen_busy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (bus.en)       state_nxt = INIT_GO;
      INIT_GO:  if (bus.init_rdy) state_nxt = INIT_RUN;
      INIT_RUN: if (complete)     state_nxt = KSA_GO;
                else if (tmo_hit) state_nxt = IDLE;
      KSA_GO:   if (bus.ksa_rdy)  state_nxt = KSA_RUN;
      KSA_RUN:  if (complete)     state_nxt = PRGA_GO;
                else if (tmo_hit) state_nxt = IDLE;
      PRGA_GO:  if (bus.prga_rdy) state_nxt = PRGA_RUN;
      PRGA_RUN: if (complete)     state_nxt = IDLE;
                else if (tmo_hit) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      seen_busy <= 1'b0;
      key_r     <= '0;
    end else begin
      state <= state_nxt;
      if (accept)
        key_r <= bus.key;
      if (run_entry)
        seen_busy <= 1'b0;
      else if (is_run && !own_rdy)
        seen_busy <= 1'b1;
    end
  end

`ifdef ARC4_SCHED_TIMEOUT_EN
  logic [15:0] tmo_cnt;
  logic        err_r;

  assign tmo_hit = is_run && (tmo_cnt == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_r   <= 1'b0;
    end else begin
      if (run_entry)
        tmo_cnt <= '0;
      else if (is_run)
        tmo_cnt <= tmo_cnt + 16'd1;
      if (accept)
        err_r <= 1'b0;
      else if (tmo_hit && !complete)
        err_r <= 1'b1;
    end
  end

  assign bus.err = err_r;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign tmo_hit        = 1'b0;
  assign bus.err        = 1'b0;
`endif

  assign bus.rdy     = (state == IDLE);
  assign bus.phase   = owner;
  assign bus.key_q   = key_r;
  assign bus.init_en = (state == INIT_GO) && bus.init_rdy;
  assign bus.ksa_en  = (state == KSA_GO)  && bus.ksa_rdy;
  assign bus.prga_en = (state == PRGA_GO) && bus.prga_rdy;

  always_comb begin
    bus.s_addr   = 8'd0;
    bus.s_wrdata = 8'd0;
    bus.s_wren   = 1'b0;
    case (owner)
      2'd1: begin
        bus.s_addr   = bus.init_addr;
        bus.s_wrdata = bus.init_wrdata;
        bus.s_wren   = bus.init_wren;
      end
      2'd2: begin
        bus.s_addr   = bus.ksa_addr;
        bus.s_wrdata = bus.ksa_wrdata;
        bus.s_wren   = bus.ksa_wren;
      end
      2'd3: begin
        bus.s_addr   = bus.prga_addr;
        bus.s_wrdata = bus.prga_wrdata;
        bus.s_wren   = bus.prga_wren;
      end
      default: begin
        bus.s_addr   = 8'd0;
        bus.s_wrdata = 8'd0;
        bus.s_wren   = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_arc4_sched.sv
// Scoreboard bench for arc4_sched: engine models drop rdy for a set number of cycles after each en pulse.
module tb_arc4_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  arc4_sched_if #(.KEY_W(24)) bus ();

  arc4_sched #(.KEY_W(24), .TIMEOUT(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Engine models
  int          init_len = 256, ksa_len = 768, prga_len = 40;
  logic [15:0] init_cnt = 16'd0, ksa_cnt = 16'd0, prga_cnt = 16'd0;
  logic        init_hang = 1'b0, ksa_block = 1'b0, init_force = 1'b0;

  always @(posedge clk) begin
    if (bus.init_en)                     init_cnt <= 16'(init_len);
    else if (init_cnt != 0 && !init_hang) init_cnt <= init_cnt - 16'd1;
    if (bus.ksa_en)                      ksa_cnt  <= 16'(ksa_len);
    else if (ksa_cnt != 0)               ksa_cnt  <= ksa_cnt - 16'd1;
    if (bus.prga_en)                     prga_cnt <= 16'(prga_len);
    else if (prga_cnt != 0)              prga_cnt <= prga_cnt - 16'd1;
  end

  assign bus.init_rdy    = (init_cnt == 16'd0);
  assign bus.ksa_rdy     = (ksa_cnt == 16'd0) && !ksa_block;
  assign bus.prga_rdy    = (prga_cnt == 16'd0);
  assign bus.init_addr   = init_force ? 8'hAA : (init_cnt[7:0] ^ 8'h10);
  assign bus.init_wrdata = init_cnt[7:0] ^ 8'h5A;
  assign bus.init_wren   = init_force ? 1'b1 : ((init_cnt != 0) && init_cnt[0]);
  assign bus.ksa_addr    = ksa_cnt[7:0] ^ 8'h20;
  assign bus.ksa_wrdata  = ksa_cnt[7:0] ^ 8'hC3;
  assign bus.ksa_wren    = (ksa_cnt != 0) && ksa_cnt[0];
  assign bus.prga_addr   = prga_cnt[7:0] ^ 8'h30;
  assign bus.prga_wrdata = prga_cnt[7:0] ^ 8'h96;
  assign bus.prga_wren   = (prga_cnt != 0) && !prga_cnt[0];

  // Scoreboard: expected engine start order, pushed at run start, popped on each en pulse.
  logic [1:0]  exp_q[$];
  logic [23:0] exp_key = 24'h0;

  task automatic see_pulse(input logic [1:0] id);
    if (exp_q.size() == 0) check_eq("unexpected_en", id, 0);
    else                   check_eq("en_order", id, exp_q.pop_front());
    check_eq("key_q_at_en", bus.key_q, exp_key);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.init_en) see_pulse(2'd1);
      if (bus.ksa_en)  see_pulse(2'd2);
      if (bus.prga_en) see_pulse(2'd3);
    end
  end

  task automatic start_run(input logic [23:0] k, input bit init_only);
    @(negedge clk);
    bus.en  = 1'b1;
    bus.key = k;
    exp_key = k;
    exp_q.push_back(2'd1);
    if (!init_only) begin
      exp_q.push_back(2'd2);
      exp_q.push_back(2'd3);
    end
    @(negedge clk);
    bus.en  = 1'b0;
    bus.key = 24'h0;
    check_eq("start_rdy", bus.rdy, 0);
    check_eq("start_phase", bus.phase, 1);
  endtask

  task automatic wait_phase(input logic [1:0] p, input int budget);
    for (int i = 0; i < budget && bus.phase !== p; i++) @(negedge clk);
    check_eq("wait_phase", bus.phase, p);
  endtask

  task automatic wait_rdy(input int budget);
    for (int i = 0; i < budget && bus.rdy !== 1'b1; i++) @(negedge clk);
    check_eq("wait_rdy", bus.rdy, 1);
    check_eq("done_queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en  = 1'b0;
    bus.key = 24'h0;
    rst     = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_eq("rst_rdy", bus.rdy, 1);
    check_eq("rst_phase", bus.phase, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_en", {bus.init_en, bus.ksa_en, bus.prga_en}, 0);
    check_eq("rst_s_wren", bus.s_wren, 0);
    check_eq("rst_s_addr", bus.s_addr, 0);
    check_eq("rst_s_wrdata", bus.s_wrdata, 0);
    check_eq("rst_key_q", bus.key_q, 0);

    // Nominal run with mux isolation and a rejected en mid-run.
    start_run(24'h00033C, 1'b0);
    wait_phase(2'd2, 600);
    repeat (10) @(negedge clk);
    init_force = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_eq("mux_s_wren", bus.s_wren, bus.ksa_wren);
      check_eq("mux_s_addr", bus.s_addr, bus.ksa_addr);
      check_eq("mux_s_wrdata", bus.s_wrdata, bus.ksa_wrdata);
    end
    init_force = 1'b0;
    bus.en  = 1'b1;
    bus.key = 24'hFFFFFF;
    @(negedge clk);
    bus.en  = 1'b0;
    bus.key = 24'h0;
    check_eq("busy_en_key_q", bus.key_q, 24'h00033C);
    check_eq("busy_en_rdy", bus.rdy, 0);
    check_eq("busy_en_phase", bus.phase, 2);
    wait_rdy(3000);
    check_eq("idle_phase", bus.phase, 0);
    check_eq("idle_s_wren", bus.s_wren, 0);
    check_eq("idle_s_addr", bus.s_addr, 0);
    check_eq("idle_key_q", bus.key_q, 24'h00033C);
    check_eq("idle_err", bus.err, 0);

    // KSA engine busy when its GO state is entered.
    init_len = 6; ksa_len = 8; prga_len = 10;
    ksa_block = 1'b1;
    start_run(24'h123456, 1'b0);
    wait_phase(2'd2, 100);
    for (int i = 0; i < 5; i++) begin
      check_eq("go_wait_ksa_en", bus.ksa_en, 0);
      check_eq("go_wait_phase", bus.phase, 2);
      @(negedge clk);
    end
    ksa_block = 1'b0;
    wait_rdy(200);

    // Reset during PRGA_RUN, then a fresh run.
    prga_len = 40;
    start_run(24'hA5A5A5, 1'b0);
    wait_phase(2'd3, 200);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("midrst_rdy", bus.rdy, 1);
    check_eq("midrst_phase", bus.phase, 0);
    check_eq("midrst_s_wren", bus.s_wren, 0);
    check_eq("midrst_queue", exp_q.size(), 0);
    start_run(24'h0BEEF0, 1'b0);
    wait_rdy(300);

    // Reset and en together: reset wins.
    @(negedge clk);
    rst    = 1'b1;
    bus.en = 1'b1;
    @(negedge clk);
    rst    = 1'b0;
    bus.en = 1'b0;
    check_eq("rst_en_rdy", bus.rdy, 1);
    check_eq("rst_en_phase", bus.phase, 0);
    @(negedge clk);
    check_eq("rst_en_still_idle", bus.rdy, 1);

`ifdef ARC4_SCHED_TIMEOUT_EN
    // Init engine never finishes: abort after 16 INIT_RUN cycles.
    init_len  = 4;
    init_hang = 1'b1;
    start_run(24'h777777, 1'b1);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_eq("tmo_running", bus.rdy, 0);
    end
    @(negedge clk);
    check_eq("tmo_rdy", bus.rdy, 1);
    check_eq("tmo_err", bus.err, 1);
    check_eq("tmo_phase", bus.phase, 0);
    check_eq("tmo_queue", exp_q.size(), 0);
    init_hang = 1'b0;
    start_run(24'h000001, 1'b0);
    check_eq("tmo_err_cleared", bus.err, 0);
    wait_rdy(300);
    check_eq("tmo_final_err", bus.err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
